// File: rtl/pipelined_cla_adder_if.sv
// Valid/ready operand and result bundle for pipelined_cla_adder.
interface pipelined_cla_adder_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_op;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_op, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one 8-bit slice per stage (WIDTH multiple of 8).
// Define PIPELINED_CLA_ADDER_FLAGS_EN to build the out_ovf / out_zero flag logic.
module pipelined_cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  pipelined_cla_adder_if.slave bus
);
  localparam int N = WIDTH / 8;

  logic             v_q [N];
  logic             v_d [N];
  logic             c_q [N];
  logic             c_d [N];
  logic [WIDTH-1:0] a_q [N];
  logic [WIDTH-1:0] a_d [N];
  logic [WIDTH-1:0] b_q [N];
  logic [WIDTH-1:0] b_d [N];
  logic [WIDTH-1:0] s_q [N];
  logic [WIDTH-1:0] s_d [N];
  logic             adv;

  function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    g    = a & b;
    p    = a | b;
    c[0] = ci;
    for (int i = 0; i < 8; i++) c[i+1] = g[i] | (p[i] & c[i]);
    return {c[8], a ^ b ^ c[7:0]};
  endfunction

  // Single global advance: the whole pipe moves or the whole pipe holds.
  assign adv = !v_q[N-1] || bus.out_ready;

  always_comb begin
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] lo;
    logic             ci;
    logic             vi;
    logic [8:0]       r;
    for (int k = 0; k < N; k++) begin
      if (k == 0) begin
        op_a = bus.in_a;
        op_b = bus.in_op ? ~bus.in_b : bus.in_b;
        ci   = bus.in_op | bus.in_cin;
        lo   = '0;
        vi   = bus.in_valid;
      end else begin
        op_a = a_q[k-1];
        op_b = b_q[k-1];
        ci   = c_q[k-1];
        lo   = s_q[k-1];
        vi   = v_q[k-1];
      end
      r = cla8(op_a[8*k +: 8], op_b[8*k +: 8], ci);
      a_d[k]          = op_a;
      b_d[k]          = op_b;
      s_d[k]          = lo;
      s_d[k][8*k +: 8] = r[7:0];
      c_d[k]          = r[8];
      v_d[k]          = vi;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q <= v_d;
      c_q <= c_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q[N-1];
  assign bus.out_sum   = s_q[N-1];
  assign bus.out_cout  = c_q[N-1];

`ifdef PIPELINED_CLA_ADDER_FLAGS_EN
  logic ovf_d;
  logic ovf_q;
  logic zero_d;
  logic zero_q;

  // Flags come from the last stage's operand slice (b already inverted for sub).
  always_comb begin
    ovf_d  = (a_d[N-1][WIDTH-1] == b_d[N-1][WIDTH-1]) &&
             (s_d[N-1][WIDTH-1] != a_d[N-1][WIDTH-1]);
    zero_d = (s_d[N-1] == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.out_ovf  = ovf_q;
  assign bus.out_zero = zero_q;
`else
  assign bus.out_ovf  = 1'b0;
  assign bus.out_zero = 1'b0;
`endif
endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor. It processes one 8-bit lookahead slice per pipeline stage, so wide operands (32 bits and up) close timing at the CPU clock. It accepts one operation per cycle behind a valid/ready handshake with full backpressure. It sits between the ALU operand latch and the writeback mux, and is also used standalone for address and accumulator arithmetic.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 8, minimum 8
- N (localparam), WIDTH/8, number of slices = number of pipeline stages
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; pipeline cleared while low
- in_valid  input  1  operation presented
- in_ready  output  1  adder can accept this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  1  0 = A+B+in_cin, 1 = A−B (A + ~B + 1; in_cin ignored)
- in_cin  input  1  carry-in for add (multi-word chaining)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry out of MSB (for sub: 1 = no borrow)
- out_ovf  output  1  signed overflow
- out_zero  output  1  out_sum == 0

## Operation
- Slice k (k = 0..N−1) handles bits [8k+7:8k] with full 8-bit lookahead: g = a&b, p = a|b, internal carries, sum = a^b^c.
- Stage k registers the following:
  - slice k sum and carry-out;
  - all lower-slice sums, already computed, delayed to stay aligned;
  - the upper operand slices, not yet consumed, skewed forward;
  - a valid bit.
- The carry into slice 0 is in_cin for add and 1 for sub. The carry into slice k>0 is the registered carry-out of stage k−1.
- For sub, B is inverted at input before registering; upper slices carry the inverted value.
- out_ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the post-inversion B. It is computed in stage N−1.
- out_zero is computed in the final stage from the assembled sum.
- Flow control is a single global advance: adv = !out_valid || out_ready. All stages shift when adv=1 and hold otherwise. in_ready = adv.
- Bubbles (valid=0) propagate through stages and are squeezed out only at the output.
- Order is strictly preserved. No operation is dropped or duplicated.

## Timing
- Reset (async assert, sync release on clock):
  - all stage valid bits, out_valid, out_sum, out_cout, out_ovf and out_zero go to 0;
  - in_ready = 1 on the first cycle after release.
- Latency: an op accepted in cycle 0 (in_valid && in_ready) shows out_valid=1 in cycle N when there is no stall. For WIDTH=32 that is 4 cycles; for WIDTH=8 it is 1.
- Throughput is 1 op/cycle when out_ready is held high.
- Stall: with out_valid=1 and out_ready=0:
  - all stages hold;
  - in_ready=0 in the same cycle (combinational from out_ready);
  - outputs stay stable until the handshake completes.
- On the cycle out_ready rises, the output is consumed, the pipeline shifts, and a new input can be accepted in that same cycle.
- in_valid=0 while adv=1 inserts a bubble. out_valid drops N cycles later if nothing follows.
- Reset asserted mid-operation discards every in-flight op immediately. Nothing emerges after release.
- Inputs are only sampled when in_valid && in_ready. Operand changes while in_ready=0 have no effect.

## Configuration
- PIPELINED_CLA_ADDER_FLAGS_EN
  - Defined: out_ovf and out_zero are computed and registered as above.
  - Undefined: out_ovf and out_zero are tied to 0 and their logic and registers are removed. out_cout and out_sum are unaffected.

## Test plan
- Reset: hold reset low for 3 cycles with in_valid=1. Required: out_valid=0, out_sum=0, no accept. After release: in_ready=1, first accept on the next valid.
- Add wrap (WIDTH=32, flags on): 0xFFFFFFFF + 0x00000001, op=0, cin=0. Required 4 cycles later: out_sum=0x00000000, cout=1, zero=1, ovf=0.
- Sub overflow: 0x80000000 − 0x00000001. Required: out_sum=0x7FFFFFFF, cout=1, ovf=1, zero=0. Also 0x00000005 − 0x00000007 gives 0xFFFFFFFE, cout=0, ovf=0.
- Backpressure stream: 8 back-to-back adds i + 0x10000000·i (i = 0..7), with out_ready low for 3 cycles after the 2nd result. Required: all 8 results in order, none lost or duplicated, and in_ready=0 exactly while stalled.
- Mid-flight reset: accept 3 ops, assert reset for 1 cycle, release, then idle. Required: out_valid stays 0 for 10 cycles.
- WIDTH=8 instance: 0x7F + 0x01. Required 1 cycle later: out_sum=0x80, ovf=1, cout=0. Repeat with the macro undefined: ovf=0, zero=0, sum unchanged.
